// File: rtl/sam_pkg.sv
// Shared types and constants for the SAM decoder and its pulse-width serialiser.
package sam_pkg;

    localparam int KEY_W  = 16;
    localparam int N_W    = 4;
    localparam int NMAX   = 4;
    localparam int PW_W   = 6;
    localparam int IDX_W  = 5;
    localparam int FCNT_W = 6;

    typedef enum logic [1:0] {
        START = 2'd0,
        CONFG = 2'd1,
        NORM  = 2'd2,
        SEND  = 2'd3
    } state_t;

    // Returns a mask with the low 'len' bits set, where len is 0..KEY_W.
    function automatic logic [KEY_W-1:0] len_mask(input logic [IDX_W-1:0] len);
        logic [KEY_W-1:0] m;
        for (int i = 0; i < KEY_W; i++) m[i] = (i < int'(len));
        return m;
    endfunction

endpackage

// File: rtl/sam_pwm_tx.sv
// Per-bit high/low phase generator: '1' = TH high then TL low, '0' = TL high then TH low.
module sam_pwm_tx
    import sam_pkg::*;
#(
    parameter int TH = 12,
    parameter int TL = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_in,
    input  logic abort,
    output logic tx,
    output logic done
);

    logic [PW_W-1:0] cnt;
    logic            busy;
    logic            hi_ph;
    logic            bit_q;

    // Combinational so the caller can chain the next bit with no idle cycle.
    assign done = busy && !hi_ph && (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            busy  <= 1'b0;
            hi_ph <= 1'b0;
            bit_q <= 1'b0;
            tx    <= 1'b0;
        end else if (abort) begin
            cnt   <= '0;
            busy  <= 1'b0;
            hi_ph <= 1'b0;
            bit_q <= 1'b0;
            tx    <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            hi_ph <= 1'b1;
            bit_q <= bit_in;
            tx    <= 1'b1;
            cnt   <= bit_in ? PW_W'(TH - 1) : PW_W'(TL - 1);
        end else if (busy) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (hi_ph) begin
                hi_ph <= 1'b0;
                tx    <= 1'b0;
                cnt   <= bit_q ? PW_W'(TL - 1) : PW_W'(TH - 1);
            end else begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sam_dec.sv
// SAM decoder: serial key configuration, XOR/erasure decode of a word, and
// pulse-width serialisation of the decoded word on tx.
module sam_dec
    import sam_pkg::*;
#(
    parameter int TH = 12,
    parameter int TL = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             str,
    input  logic             mode,
    input  logic [KEY_W-1:0] msgcd,
    input  logic             valid,
    input  logic [9:0]       cc,
    output logic [KEY_W-1:0] msg,
    output logic [KEY_W-1:0] erase,
    output logic             dvalid,
    output logic             tx,
    output logic             tx_busy,
    output logic             err
);

    state_t state, state_n;

    // Frame shift registers and their committed working copies
    logic [N_W-1:0]    n_sh;
    logic [KEY_W-1:0]  d_sh, nk_sh;
    logic [FCNT_W-1:0] fcnt;
    logic              bad;
    logic [KEY_W-1:0]  d_w, nk_w;
    logic [IDX_W-1:0]  len_w;

    logic [IDX_W-1:0]  idx;
    logic              term;

    logic [IDX_W-1:0]  len_c;
    logic [FCNT_W-1:0] flen;
    logic              frame_full, frame_bit, frame_start;
    logic [KEY_W-1:0]  lmask, msg_d, erase_d;
    logic [3:0]        top_idx;
    logic              accept;
    logic              pwm_start, pwm_bit, pwm_abort, pwm_tx, pwm_done;

    assign len_c       = IDX_W'(1) << n_sh;
    assign flen        = FCNT_W'(4) + FCNT_W'({len_c, 1'b0});
    assign frame_full  = !bad && (fcnt >= FCNT_W'(4)) && (fcnt == flen);
    assign frame_start = mode && (state != CONFG);
    assign frame_bit   = (state == CONFG) && mode && !bad && !frame_full;

    assign lmask   = len_mask(len_w);
    assign msg_d   = (msgcd ^ d_w) & ~nk_w & lmask;
    assign erase_d = nk_w & lmask;
    assign top_idx = 4'(len_w - 1'b1);
    assign accept  = (state == NORM) && !mode && valid;

    assign pwm_start = accept || ((state == SEND) && !mode && pwm_done && (idx != '0));
    assign pwm_bit   = accept ? msg_d[top_idx] : msg[4'(idx - 1'b1)];
    assign pwm_abort = (state == SEND) && mode;

    assign tx      = (state == SEND) && (pwm_tx || term);
    assign tx_busy = (state == SEND);

    sam_pwm_tx #(.TH(TH), .TL(TL)) u_pwm (
        .clk    (clk),
        .reset  (reset),
        .start  (pwm_start),
        .bit_in (pwm_bit),
        .abort  (pwm_abort),
        .tx     (pwm_tx),
        .done   (pwm_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= START;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            START: if (mode) state_n = CONFG;
            CONFG: if (!mode) state_n = frame_full ? NORM : START;
            NORM: begin
                if (mode)       state_n = CONFG;
                else if (valid) state_n = SEND;
            end
            SEND: begin
                if (mode)      state_n = CONFG;
                else if (term) state_n = NORM;
            end
            default: state_n = START;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_sh   <= '0;
            d_sh   <= '0;
            nk_sh  <= '0;
            fcnt   <= '0;
            bad    <= 1'b0;
            d_w    <= '0;
            nk_w   <= '0;
            len_w  <= '0;
            idx    <= '0;
            term   <= 1'b0;
            msg    <= '0;
            erase  <= '0;
            dvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            dvalid <= 1'b0;

            if (state == START) begin
                n_sh  <= '0;
                d_sh  <= '0;
                nk_sh <= '0;
                fcnt  <= '0;
                bad   <= 1'b0;
                d_w   <= '0;
                nk_w  <= '0;
                len_w <= '0;
                idx   <= '0;
                term  <= 1'b0;
                err   <= 1'b0;
            end

            // The edge that first sees mode high already carries n[3].
            if (frame_start) begin
                n_sh  <= {3'b000, str};
                d_sh  <= '0;
                nk_sh <= '0;
                fcnt  <= FCNT_W'(1);
                bad   <= 1'b0;
            end else if (frame_bit) begin
                fcnt <= fcnt + 1'b1;
                if (fcnt < FCNT_W'(4)) begin
                    n_sh <= {n_sh[2:0], str};
                    if ((fcnt == FCNT_W'(3)) && ({n_sh[2:0], str} > 4'(NMAX))) begin
                        bad <= 1'b1;
                        err <= 1'b1;
                    end
                end else if (fcnt < FCNT_W'(4) + FCNT_W'(len_c)) begin
                    d_sh <= {d_sh[KEY_W-2:0], str};
                end else begin
                    nk_sh <= {nk_sh[KEY_W-2:0], str};
                end
            end

            if ((state == CONFG) && !mode && frame_full) begin
                d_w   <= d_sh;
                nk_w  <= nk_sh;
                len_w <= len_c;
            end

            if (accept) begin
                msg    <= msg_d;
                erase  <= erase_d;
                dvalid <= 1'b1;
                idx    <= {1'b0, top_idx};
                if (cc != 10'(len_w)) err <= 1'b1;
            end

            if (state == SEND) begin
                if (mode) begin
                    term <= 1'b0;
                    idx  <= '0;
                end else begin
                    if (valid) err <= 1'b1;
                    if (term) term <= 1'b0;
                    if (pwm_done) begin
                        if (idx == '0) term <= 1'b1;
                        else           idx  <= idx - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sam_dec.sv
// Randomized scoreboard bench for sam_dec: a behavioural key/decode/waveform model
// predicts each dvalid word and the tx pulse train.
module tb_sam_dec;

    localparam int TH = 12;
    localparam int TL = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        str = 1'b0, mode = 1'b0, valid = 1'b0;
    logic [15:0] msgcd = '0;
    logic [9:0]  cc = '0;
    logic [15:0] msg, erase;
    logic        dvalid, tx, tx_busy, err;

    int total = 0;
    int bad   = 0;
    int n_dv  = 0;

    typedef struct {
        logic [15:0] msg;
        logic [15:0] erase;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    // reference model state
    bit          m_norm = 0;
    int          m_len  = 0;
    logic [15:0] m_d = '0, m_n = '0;
    logic        m_err = 1'b0;
    logic [15:0] last_msg = '0;

    always #5 clk = ~clk;

    sam_dec #(.TH(TH), .TL(TL)) dut (
        .clk     (clk),
        .reset   (reset),
        .str     (str),
        .mode    (mode),
        .msgcd   (msgcd),
        .valid   (valid),
        .cc      (cc),
        .msg     (msg),
        .erase   (erase),
        .dvalid  (dvalid),
        .tx      (tx),
        .tx_busy (tx_busy),
        .err     (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_msg(input logic [15:0] w);
        logic [15:0] r = '0;
        for (int i = 0; i < m_len; i++) if (!m_n[i]) r[i] = w[i] ^ m_d[i];
        return r;
    endfunction

    function automatic logic [15:0] model_erase();
        logic [15:0] r = '0;
        for (int i = 0; i < m_len; i++) r[i] = m_n[i];
        return r;
    endfunction

    // Monitor: every dvalid must match the oldest predicted word.
    always @(negedge clk) begin
        if (reset && dvalid) begin : mon
            exp_t e;
            n_dv++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_dvalid: got msg %0h with empty scoreboard", msg);
            end else begin
                e = exp_q.pop_front();
                chk("msg", 32'(msg), 32'(e.msg));
                chk("erase", 32'(erase), 32'(e.erase));
                chk("err_at_dvalid", 32'(err), 32'(e.err));
            end
        end
    end

    // Leaves the DUT in START for one edge so err and keys are cleared.
    task automatic go_start();
        mode = 1'b1; str = 1'b0; tick();
        mode = 1'b0; tick();
        tick();
        m_norm = 0;
        m_err  = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [15:0] d, input logic [15:0] nk, input int nbits);
        bit q[$];
        int len = 1 << n;
        for (int i = 3; i >= 0; i--) q.push_back(n[i]);
        for (int i = len - 1; i >= 0; i--) q.push_back(d[i]);
        for (int i = len - 1; i >= 0; i--) q.push_back(nk[i]);
        for (int i = 0; i < nbits; i++) begin
            mode = 1'b1;
            str  = q[i];
            tick();
        end
        mode = 1'b0; str = 1'b0;
        tick();
        if (nbits >= q.size()) begin
            m_norm = 1; m_len = len; m_d = d; m_n = nk;
        end else begin
            m_norm = 0;
            tick();
            m_err = 1'b0;
        end
    endtask

    // Issues one word; when accepted, predicts it and checks the whole tx train.
    task automatic word(input logic [15:0] w, input logic [9:0] c);
        bit   acc = m_norm;
        exp_t e;
        bit   lv[$];
        int   errs = 0;
        msgcd = w; cc = c; valid = 1'b1;
        if (acc) begin
            if (int'(c) != m_len) m_err = 1'b1;
            e.msg = model_msg(w); e.erase = model_erase(); e.err = m_err;
            exp_q.push_back(e);
            last_msg = e.msg;
        end
        tick();
        valid = 1'b0;
        if (acc) begin
            for (int b = m_len - 1; b >= 0; b--) begin
                repeat (last_msg[b] ? TH : TL) lv.push_back(1'b1);
                repeat (last_msg[b] ? TL : TH) lv.push_back(1'b0);
            end
            lv.push_back(1'b1);
            lv.push_back(1'b0);
            for (int j = 0; j < lv.size(); j++) begin
                @(negedge clk);
                if (tx !== lv[j]) errs++;
                if (tx_busy !== (j < lv.size() - 1)) errs++;
            end
            chk("tx_wave", errs, 0);
        end else begin
            repeat (3) tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, dv0, quiet;
        logic [15:0] w;

        // reset state
        repeat (2) tick();
        chk("rst_msg", 32'(msg), 0);
        chk("rst_erase", 32'(erase), 0);
        chk("rst_tx", 32'(tx), 0);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk); reset = 1'b1;
        tick();

        // reference configuration and word
        send_frame(2, 16'hA, 16'h4, 12);
        word(16'h000B, 10'd4);
        chk("ref_msg", 32'(msg), 32'h0001);
        chk("ref_erase", 32'(erase), 32'h0004);
        chk("ref_err", 32'(err), 0);

        // cc mismatch: still decoded, err raised
        word(16'h1235, 10'd8);
        chk("cc_err", 32'(err), 1);

        // valid during SEND: dropped, err set, msg held
        go_start();
        chk("start_clears_err", 32'(err), 0);
        send_frame(2, 16'hA, 16'h4, 12);
        w = 16'h0007;
        msgcd = w; cc = 10'd4; valid = 1'b1;
        e_push(w);
        tick(); valid = 1'b0;
        repeat (10) tick();
        msgcd = 16'hFFFF; valid = 1'b1; tick(); valid = 1'b0;
        m_err = 1'b1;
        k = 0;
        while (tx_busy && k < 200) begin tick(); k++; end
        chk("send_done_in_time", 32'(k < 200), 1);
        chk("send_valid_err", 32'(err), 1);
        chk("send_valid_msg_held", 32'(msg), 32'(last_msg));

        // abort mid-SEND at bit 2
        go_start();
        send_frame(2, 16'h5, 16'h0, 12);
        msgcd = 16'h000F; cc = 10'd4; valid = 1'b1;
        e_push(16'h000F);
        tick(); valid = 1'b0;
        repeat (2 * (TH + TL) + 3) tick();
        mode = 1'b1; str = 1'b0;
        tick();
        chk("abort_tx", 32'(tx), 0);
        chk("abort_busy", 32'(tx_busy), 0);
        mode = 1'b0; tick(); tick();
        m_norm = 0; m_err = 1'b0;

        // n > 4: err, no NORM entry
        go_start();
        for (int i = 0; i < 7; i++) begin
            mode = 1'b1; str = (i < 4) ? (4'd5 >> (3 - i)) & 1'b1 : 1'b1;
            tick();
        end
        chk("bad_n_err", 32'(err), 1);
        mode = 1'b0; tick();
        dv0 = n_dv;
        word(16'h00FF, 10'd16);
        chk("bad_n_no_dvalid", n_dv, dv0);
        chk("bad_n_err_cleared", 32'(err), 0);

        // incomplete frame: 3 bits
        send_frame(2, 16'hA, 16'h4, 3);
        chk("incomplete_err", 32'(err), 0);
        dv0 = n_dv;
        word(16'h000B, 10'd4);
        chk("incomplete_no_dvalid", n_dv, dv0);

        // randomized configurations and words
        for (int r = 0; r < 6; r++) begin
            int n, len;
            logic [15:0] d, nk, lm;
            go_start();
            n   = $urandom_range(0, 4);
            len = 1 << n;
            lm  = 16'((32'h1 << len) - 1);
            d   = 16'($urandom) & lm;
            nk  = 16'($urandom) & 16'($urandom) & lm;
            send_frame(n, d, nk, 4 + 2 * len);
            for (int i = 0; i < 3; i++) begin
                cc = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 31)) : 10'(len);
                word(16'($urandom), cc);
            end
        end

        // reset asserted mid-SEND
        go_start();
        send_frame(3, 16'hC3, 16'h10, 20);
        msgcd = 16'h00AA; cc = 10'd8; valid = 1'b1;
        e_push(16'h00AA);
        tick(); valid = 1'b0;
        repeat (20) tick();
        reset = 1'b0;
        #1;
        chk("rstsend_msg", 32'(msg), 0);
        chk("rstsend_erase", 32'(erase), 0);
        chk("rstsend_dvalid", 32'(dvalid), 0);
        chk("rstsend_tx", 32'(tx), 0);
        chk("rstsend_busy", 32'(tx_busy), 0);
        chk("rstsend_err", 32'(err), 0);
        @(negedge clk); @(negedge clk); reset = 1'b1;
        m_norm = 0; m_err = 1'b0;
        quiet = 0;
        repeat (40) begin tick(); if (tx !== 1'b0 || tx_busy !== 1'b0) quiet++; end
        chk("rstsend_no_resume", quiet, 0);
        dv0 = n_dv;
        word(16'h1111, 10'd8);
        chk("rstsend_start_no_dvalid", n_dv, dv0);

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Pushes the model prediction for a word accepted outside the word() task.
    task automatic e_push(input logic [15:0] w);
        exp_t e;
        if (cc != 10'(m_len)) m_err = 1'b1;
        e.msg = model_msg(w); e.erase = model_erase(); e.err = m_err;
        exp_q.push_back(e);
        last_msg = e.msg;
    endtask

endmodule

// File: doc/sam_dec.md
SAM_DEC -- requirements
Module: sam_dec

Interface
REQ-001 Parameter TH, default 12: tx high-phase length in clk cycles for a decoded '1', and low-phase length for a '0'.
REQ-002 Parameter TL, default 6: tx high-phase length for a '0', and low-phase length for a '1'.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 str  in  1  serial configuration data; sampled only while mode=1.
REQ-006 mode  in  1  1 = configuration phase, 0 = normal phase.
REQ-007 msgcd  in  16  encoded word; bit i is valid for i < L.
REQ-008 valid  in  1  one-cycle strobe; msgcd and cc are valid.
REQ-009 cc  in  10  encoder bit count accompanying msgcd.
REQ-010 msg  out  16  decoded word, registered.
REQ-011 erase  out  16  erasure mask; bit i = 1 means bit i is unrecoverable.
REQ-012 dvalid  out  1  one-cycle pulse; msg and erase were updated.
REQ-013 tx  out  1  pulse-width serial output of the decoded word.
REQ-014 tx_busy  out  1  high while a word is being serialised.
REQ-015 err  out  1  sticky error flag.

Function
REQ-016 FSM states: START, CONFG, NORM, SEND; all other encodings go to START.
REQ-017 START transitions:
- mode=1 -> CONFG.
- While in START, all key registers and err are cleared.
REQ-018 Configuration frame: the first bit is sampled on the edge at which mode is first seen high in START; one bit is consumed per cycle after that.
- n[3:0], MSB first.
- d[L-1:0], MSB first.
- N[L-1:0], MSB first.
- L = 1<<n.
REQ-019 n > 4 sets err; further str bits are ignored until mode=0, which returns the FSM to START.
REQ-020 CONFG transitions:
- mode=0 before the full frame (4+2L bits) -> START, keys discarded.
- mode=0 after the full frame -> NORM, and d, N and L are committed to working registers.
REQ-021 NORM or SEND with mode=1 -> CONFG: transmission aborts, tx is driven 0 on the next cycle, and a new frame parse starts.
REQ-022 Decode in NORM when valid=1, for each bit i:
- i < L and N[i]=0: msg[i] = msgcd[i] XOR d[i].
- N[i]=1 or i >= L: msg[i] = 0.
- erase[i] = N[i] for i < L, otherwise 0.
REQ-023 Decode latency: valid at edge k -> msg, erase and dvalid=1 at edge k+1; then FSM enters SEND with tx_busy=1.
REQ-024 cc != L on an accepted word sets err; the word is still decoded.
REQ-025 valid=1 while in SEND: the word is dropped, err is set, and msg is unchanged.
REQ-026 SEND order: bits are transmitted from msg[L-1] down to msg[0]; erased bits are sent as 0.
REQ-027 SEND bit timing:
- '1' = TH cycles tx=1, then TL cycles tx=0.
- '0' = TL cycles tx=1, then TH cycles tx=0.
- Each bit is TH+TL cycles (18 at defaults), which lies inside the encoder's 10..60 acceptance window.
REQ-028 After the last bit, tx=1 for one cycle as the terminating rising edge, then tx=0; tx_busy falls that same cycle and the FSM returns to NORM.
REQ-029 tx is 0 whenever the FSM is not in SEND.
REQ-030 Counter widths:
- Phase counter: 6 bits.
- Bit index: 5 bits.
- Frame counter: 6 bits, saturating at 4+2L.
- No arithmetic wraps within legal ranges.
REQ-031 err is cleared only in START or by reset.

Reset
REQ-032 On reset low, immediately:
- FSM = START.
- msg = 0, erase = 0, dvalid = 0, tx = 0, tx_busy = 0, err = 0.
- Key registers and counters = 0.
REQ-033 Reset asserted mid-SEND aborts the transmission; no partial bit is resumed after release.

Structure
REQ-034 A shared package sam_pkg holds:
- the FSM state typedef;
- constants KEY_W=16, N_W=4, NMAX=4, PW_W=6.
REQ-035 One sub-module, sam_pwm_tx, implements the per-bit high/low phase generator (bit in, start, done).
REQ-036 sam_dec instantiates sam_pwm_tx once and owns the FSM, key registers and decode logic.

Verification
REQ-037 Config and decode: n=2, d=1010, N=0100, mode low, then msgcd=16'h000B, cc=4, valid -> next cycle msg=16'h0001, erase=16'h0004, dvalid=1, err=0.
REQ-038 Serialisation (same setup): tx sequence 0,0,0,1 -> three 6-high/12-low bits, one 12-high/6-low bit, a 1-cycle terminator, then tx_busy=0 after 4*18+1 cycles.
REQ-039 Abort: mode raised mid-SEND at bit 2 -> tx=0 the next cycle, state CONFG, tx_busy=0.
REQ-040 Errors: n=5 -> err=1 and no NORM entry; valid during SEND -> err=1 and msg unchanged; cc=8 with L=4 -> err=1 and msg still decoded.
REQ-041 Incomplete frame: mode dropped after 3 bits -> START, err=0; a following valid produces no dvalid.
REQ-042 Reset: reset pulsed low during SEND -> all outputs 0 immediately; after release, FSM in START.
